// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3 encodings and operand signedness helpers
// for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        mul    = 3'd0,
        mulh   = 3'd1,
        mulhsu = 3'd2,
        mulhu  = 3'd3,
        div    = 3'd4,
        divu   = 3'd5,
        rem    = 3'd6,
        remu   = 3'd7
    } muldiv_funct3_t;

    // MUL keeps its low half regardless of signedness, so it is treated as signed.
    function automatic logic a_is_signed(input muldiv_funct3_t op);
        return op inside {mul, mulh, mulhsu, div, rem};
    endfunction

    function automatic logic b_is_signed(input muldiv_funct3_t op);
        return op inside {mul, mulh, div, rem};
    endfunction

endpackage

// File: rtl/muldiv_unit_udiv_iter.sv
// One restoring shift-subtract step of an unsigned divide. Purely combinational;
// the remainder is always below the divisor, so it fits in XLEN bits.
module udiv_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        trial = {rem, quo[XLEN-1]};
        diff  = trial - {1'b0, divisor};
        if (trial >= {1'b0, divisor}) begin
            next_rem = diff[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            next_rem = trial[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit. Works on operand magnitudes in a
// shared 2*XLEN accumulator and applies sign correction on the way to DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    // Handshake: start is only looked at in S_IDLE; busy rises on the accepting
    // edge and falls with done; done pulses one cycle with result valid, and
    // result holds until the next accepted start.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    muldiv_funct3_t    op;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   fast_res;
    logic              fast;
    logic              neg_a;
    logic              neg_b;
    logic [CNT_W-1:0]  cnt;

    muldiv_funct3_t    op_in;
    logic              a_neg_in;
    logic              b_neg_in;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   min_val;
    logic              fast_in;
    logic [XLEN-1:0]   fast_val;

    always_comb begin
        op_in    = muldiv_funct3_t'(funct3);
        a_neg_in = a_is_signed(op_in) & a[XLEN-1];
        b_neg_in = b_is_signed(op_in) & b[XLEN-1];
        a_mag    = a_neg_in ? -a : a;
        b_mag    = b_neg_in ? -b : b;
        min_val  = {1'b1, {(XLEN-1){1'b0}}};
        // Signed divide/remainder have funct3[0]==0; remainder ops have funct3[1]==1.
        fast_in  = funct3[2] && ((b == '0) || (!funct3[0] && a == min_val && b == '1));
        if (b == '0) begin
            fast_val = funct3[1] ? a : '1;
        end else begin
            fast_val = funct3[1] ? '0 : a;
        end
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   div_quo;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc[XLEN-1:1]};
    end

    udiv_iter #(.XLEN(XLEN)) u_udiv_iter (
        .rem      (acc[2*XLEN-1:XLEN]),
        .quo      (acc[XLEN-1:0]),
        .divisor  (opb),
        .next_rem (div_rem),
        .next_quo (div_quo)
    );

    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_c = (neg_a ^ neg_b) ? -acc : acc;
        quo_c  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_c  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            mul:          final_res = prod_c[XLEN-1:0];
            mulh, mulhsu,
            mulhu:        final_res = prod_c[2*XLEN-1:XLEN];
            div, divu:    final_res = quo_c;
            default:      final_res = rem_c;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op       <= mul;
            acc      <= '0;
            opb      <= '0;
            fast_res <= '0;
            fast     <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op       <= op_in;
                        neg_a    <= a_neg_in;
                        neg_b    <= b_neg_in;
                        opb      <= b_mag;
                        acc      <= {{XLEN{1'b0}}, a_mag};
                        fast     <= fast_in;
                        fast_res <= fast_val;
                        busy     <= 1'b1;
                        // Fast path parks in S_DIV with a zero count so it finishes on the next edge.
                        if (fast_in) begin
                            cnt   <= '0;
                            state <= S_DIV;
                        end else begin
                            cnt   <= CNT_W'(XLEN);
                            state <= funct3[2] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt != '0) begin
                        acc <= (state == S_MUL) ? mul_next : {div_rem, div_quo};
                        cnt <= cnt - 1'b1;
                    end else begin
                        result <= fast ? fast_res : final_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN=32: results, latency, busy/done
// timing, ignored starts and asynchronous reset during an operation.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_checks = 0;
    int n_fails  = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one operation and waits (bounded) for done; lat is the edge index
    // after which done was seen, counting the start edge as edge 0.
    task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] av,
                          input logic [XLEN-1:0] bv, output logic [XLEN-1:0] res,
                          output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        funct3 = op;
        a      = av;
        b      = bv;
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        lat   = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        res = result;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fails++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [XLEN-1:0] res;
        int lat;
        bit busy_ok;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'hFFFFFFEB) begin
            n_fails++;
            $display("FAIL mul_result: got %h, required FFFFFFEB", res);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fails++;
            $display("FAIL mul_latency: got %0d, required 33", lat);
        end
        n_checks++;
        if (!busy_ok) begin
            n_fails++;
            $display("FAIL mul_busy: busy dropped before done, required high throughout");
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFEB) begin
            n_fails++;
            $display("FAIL mul_after_done: done=%b busy=%b result=%h, required 0 0 FFFFFFEB",
                     done, busy, result);
        end
    endtask

    task automatic test_mul_high();
        logic [2:0]      ops [4];
        logic [XLEN-1:0] av  [4];
        logic [XLEN-1:0] bv  [4];
        logic [XLEN-1:0] exp [4];
        logic [XLEN-1:0] res;
        int lat;
        bit busy_ok;
        ops = '{3'd1, 3'd3, 3'd2, 3'd1};
        av  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        bv  = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        exp = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat, busy_ok);
            n_checks++;
            if (res !== exp[i] || lat !== 33) begin
                n_fails++;
                $display("FAIL mul_high_%0d: got %h lat %0d, required %h lat 33", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]      ops [4];
        logic [XLEN-1:0] av  [4];
        logic [XLEN-1:0] bv  [4];
        logic [XLEN-1:0] exp [4];
        logic [XLEN-1:0] res;
        int lat;
        bit busy_ok;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        av  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd7};
        bv  = '{32'd2, 32'd2, 32'd2, 32'd3};
        exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd1};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat, busy_ok);
            n_checks++;
            if (res !== exp[i] || lat !== 33 || !busy_ok) begin
                n_fails++;
                $display("FAIL div_%0d: got %h lat %0d busy_ok %0d, required %h lat 33 busy_ok 1",
                         i, res, lat, busy_ok, exp[i]);
            end
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]      ops [6];
        logic [XLEN-1:0] av  [6];
        logic [XLEN-1:0] bv  [6];
        logic [XLEN-1:0] exp [6];
        logic [XLEN-1:0] res;
        int lat;
        bit busy_ok;
        ops = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
        av  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
        bv  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        exp = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], bv[i], res, lat, busy_ok);
            n_checks++;
            if (res !== exp[i] || lat !== 1) begin
                n_fails++;
                $display("FAIL fast_%0d: got %h lat %0d, required %h lat 1", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt = 0;
        int lat = -1;
        logic [XLEN-1:0] res = '0;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        a      = 32'd100;
        b      = 32'd7;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 9) begin
                start  = 1'b1;
                funct3 = 3'd0;
                a      = 32'd5;
                b      = 32'd6;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                lat = cyc;
                res = result;
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fails++;
            $display("FAIL ignore_done_count: got %0d pulses, required 1", done_cnt);
        end
        n_checks++;
        if (res !== 32'd14 || lat !== 33) begin
            n_fails++;
            $display("FAIL ignore_result: got %h lat %0d, required 0000000e lat 33", res, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        int done_cnt = 0;
        logic [XLEN-1:0] res;
        int lat;
        bit busy_ok;
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd0;
        a      = 32'h12345678;
        b      = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fails++;
            $display("FAIL reset_mid_op: busy=%b done=%b result=%h, required 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt !== 0) begin
            n_fails++;
            $display("FAIL reset_no_done: got %0d pulses, required 0", done_cnt);
        end
        run_op(3'd0, 32'd3, 32'd4, res, lat, busy_ok);
        n_checks++;
        if (res !== 32'd12 || lat !== 33) begin
            n_fails++;
            $display("FAIL mul_after_reset: got %h lat %0d, required 0000000c lat 33", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_ignore_start();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
